// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file completer.
// Word-level helpers take 64-bit operands so that every legal DATA_WIDTH fits.
package apb_pkg;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} apb_state_e;

  // Number of byte-address bits below the word index.
  function automatic int unsigned align_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic valid_align(input logic [63:0] addr, input int unsigned data_width);
    logic [63:0] mask;
    mask = 64'(data_width / 8) - 64'd1;
    return (addr & mask) == 64'd0;
  endfunction

  function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_word;
    for (int k = 0; k < 8; k++) begin
      if (strb[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage with a byte-strobed write port and a combinational read port.
// Read-only registers ignore writes; all registers reset to RESET_VAL.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           IDX_WIDTH  = 8,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IDX_WIDTH-1:0]    widx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [IDX_WIDTH-1:0]    ridx_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Out-of-range read indices return zero.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_d[i] = regs_q[i];
      if (we_i && !RO_MASK[i] && (int'(widx_i) == i)) begin
        regs_d[i] = DATA_WIDTH'(strb_merge(64'(regs_q[i]), 64'(wdata_i), 8'(wstrb_i)));
      end
      if (int'(ridx_i) == i) rdata_o = regs_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: rtl/apb_regfile_peripheral.sv
// APB4 completer fronting a parametrised register bank, with wait states,
// full error decode and a saturating count of error responses and aborts.
module apb_regfile_peripheral
  import apb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [7:0]              err_count
);

  localparam int unsigned AlignBits = align_bits(DATA_WIDTH);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  apb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [StrbWidth-1:0]   strb_q, strb_d;
  logic                   err_q, err_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic [ADDR_WIDTH-1:0]  idx_in, idx_q;
  logic                   ro_hit, range_err, setup_err;
  logic                   bus_access, inputs_match, abort, complete, bank_we;
  logic [DATA_WIDTH-1:0]  bank_rdata;

  assign idx_in = paddr >> AlignBits;
  assign idx_q  = addr_q >> AlignBits;

  always_comb begin
    ro_hit = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (int'(idx_in) == i) ro_hit = RO_MASK[i];
    end
  end

  // Decoded from the setup-phase address and registered, so outputs never see paddr directly.
  assign range_err = int'(idx_in) >= int'(NUM_REGS);
  assign setup_err = !valid_align(64'(paddr), DATA_WIDTH) || range_err || (pwrite && ro_hit);

  assign bus_access   = psel && penable;
  assign inputs_match = (paddr == addr_q) && (pwrite == wr_q) && (pwdata == wdata_q) &&
                        (pstrb == strb_q);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    abort    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = setup_err;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StSetup;
        end else if (psel && penable) begin
          // Access without a setup phase: answer with an error next cycle.
          err_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = StAccess;
        end
      end
      StSetup: begin
        if (!bus_access || !inputs_match) begin
          abort = 1'b1;
        end else if (cnt_q == 4'd0) begin
          complete = 1'b1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
        end else if (!bus_access || !inputs_match) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort || complete) state_d = StIdle;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((abort || (complete && err_q)) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  assign bank_we = complete && wr_q && !err_q;

  always_comb begin
    pready    = (state_q != StIdle) && (cnt_q == 4'd0);
    pslverr   = pready && err_q;
    prdata    = (pready && !wr_q && !err_q) ? bank_rdata : '0;
    err_count = err_cnt_q;
  end

  apb_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK),
    .RESET_VAL  (RESET_VAL)
  ) u_reg_bank (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .we_i    (bank_we),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .ridx_i  (idx_q),
    .rdata_o (bank_rdata)
  );

endmodule

// File: tb/tb_apb_regfile_peripheral.sv
// Bench for apb_regfile_peripheral: two instances (no wait states with RO reg 0,
// and three wait states with a non-zero reset value) checked through a response scoreboard.
module tb_apb_regfile_peripheral;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       psel, penable, pwrite;
  logic [1:0][7:0]  paddr;
  logic [1:0][31:0] pwdata;
  logic [1:0][3:0]  pstrb;
  logic [1:0][31:0] prdata;
  logic [1:0]       pready, pslverr;
  logic [1:0][7:0]  err_count;

  always #5 clk = ~clk;

  apb_regfile_peripheral #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (8),
    .NUM_REGS    (16),
    .WAIT_STATES (0),
    .RO_MASK     (16'h0001),
    .RESET_VAL   (32'h0000_0000)
  ) dut0 (
    .pclk (clk), .presetn (rst_n), .psel (psel[0]), .penable (penable[0]),
    .pwrite (pwrite[0]), .paddr (paddr[0]), .pwdata (pwdata[0]), .pstrb (pstrb[0]),
    .prdata (prdata[0]), .pready (pready[0]), .pslverr (pslverr[0]),
    .err_count (err_count[0])
  );

  apb_regfile_peripheral #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (8),
    .NUM_REGS    (16),
    .WAIT_STATES (3),
    .RO_MASK     (16'h0000),
    .RESET_VAL   (32'hA5A5_5A5A)
  ) dut1 (
    .pclk (clk), .presetn (rst_n), .psel (psel[1]), .penable (penable[1]),
    .pwrite (pwrite[1]), .paddr (paddr[1]), .pwdata (pwdata[1]), .pstrb (pstrb[1]),
    .prdata (prdata[1]), .pready (pready[1]), .pslverr (pslverr[1]),
    .err_count (err_count[1])
  );

  typedef struct {
    int          dut;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completed response is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pready[d]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_pready dut%0d", d), 32'(pready[d]), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, " dut"}, 32'(d), 32'(mon_e.dut));
          check({mon_e.name, " pslverr"}, 32'(pslverr[d]), 32'(mon_e.err));
          check({mon_e.name, " prdata"}, prdata[d], mon_e.rdata);
        end
      end
    end
  end

  // Full transfer; returns with psel low so a following call is back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic err,
                      input logic [31:0] rdata, input int waits, input string name);
    int   cyc;
    logic done;
    exp_q.push_back('{d, err, rdata, name});
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      done = pready[d];
      if (!done) check({name, " prdata_while_waiting"}, prdata[d], 32'd0);
      @(posedge clk); #1;
    end
    check({name, " latency"}, 32'(cyc), 32'(waits + 1));
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic no_setup(input int d);
    exp_q.push_back('{d, 1'b1, 32'd0, "no_setup"});
    psel[d] = 1'b1; penable[d] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("no_setup pready", 32'(pready[d]), 32'd1);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset pready%0d", d), 32'(pready[d]), 32'd0);
      check($sformatf("reset pslverr%0d", d), 32'(pslverr[d]), 32'd0);
      check($sformatf("reset prdata%0d", d), prdata[d], 32'd0);
      check($sformatf("reset err_count%0d", d), 32'(err_count[d]), 32'd0);
    end
    rst_n = 1'b1;
    idle(1);

    // Zero wait states: full write then read back.
    xfer(0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0, 0, "t1_write");
    xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 1'b0, 32'hDEAD_BEEF, 0, "t1_read");

    // Byte-lane merge and the strobe-free no-op write.
    xfer(0, 1'b1, 8'h08, 32'h1122_3344, 4'hF, 1'b0, 32'd0, 0, "t2_init");
    xfer(0, 1'b1, 8'h08, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'd0, 0, "t2_merge");
    xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 1'b0, 32'h11BB_33DD, 0, "t2_read");
    xfer(0, 1'b1, 8'h08, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'd0, 0, "t2_nostrb");
    xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 1'b0, 32'h11BB_33DD, 0, "t2_read_nostrb");
    xfer(0, 1'b1, 8'h3C, 32'h0F0F_1234, 4'hF, 1'b0, 32'd0, 0, "t2_last_write");
    xfer(0, 1'b0, 8'h3C, 32'd0, 4'h0, 1'b0, 32'h0F0F_1234, 0, "t2_last_read");
    idle(1);

    // Three wait states.
    xfer(1, 1'b0, 8'h04, 32'd0, 4'h0, 1'b0, 32'hA5A5_5A5A, 3, "t3_read_reset");
    xfer(1, 1'b1, 8'h04, 32'h1357_9BDF, 4'hF, 1'b0, 32'd0, 3, "t3_write");
    xfer(1, 1'b0, 8'h04, 32'd0, 4'h0, 1'b0, 32'h1357_9BDF, 3, "t3_read");
    idle(1);

    // Error decode.
    xfer(0, 1'b0, 8'h06, 32'd0, 4'h0, 1'b1, 32'd0, 0, "t4_misaligned");
    xfer(0, 1'b0, 8'h40, 32'd0, 4'h0, 1'b1, 32'd0, 0, "t4_out_of_range");
    xfer(0, 1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0, 0, "t4_ro_write");
    idle(1);
    check("t4 err_count", 32'(err_count[0]), 32'd3);
    xfer(0, 1'b0, 8'h00, 32'd0, 4'h0, 1'b0, 32'd0, 0, "t4_ro_read");
    xfer(0, 1'b1, 8'h0A, 32'h5555_5555, 4'hF, 1'b1, 32'd0, 0, "t4_misaligned_write");
    xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 1'b0, 32'h11BB_33DD, 0, "t4_unchanged");
    idle(1);
    check("t4 err_count_after", 32'(err_count[0]), 32'd4);

    // Protocol violations on the waited instance.
    no_setup(1);
    idle(1);
    check("t5 err_count_no_setup", 32'(err_count[1]), 32'd1);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h0C; pwdata[1] = 32'h1234_5678; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    idle(2);
    psel[1] = 1'b0; penable[1] = 1'b0;
    idle(2);
    check("t5 err_count_mid_wait_abort", 32'(err_count[1]), 32'd2);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h0C;
    idle(2);
    psel[1] = 1'b0;
    idle(1);
    check("t5 err_count_setup_abort", 32'(err_count[1]), 32'd3);
    xfer(1, 1'b0, 8'h0C, 32'd0, 4'h0, 1'b0, 32'hA5A5_5A5A, 3, "t5_no_write");

    for (int i = 0; i < 300; i++) begin
      xfer(0, 1'b0, 8'h06, 32'd0, 4'h0, 1'b1, 32'd0, 0, "t5_flood");
    end
    idle(1);
    check("t5 err_count_saturated", 32'(err_count[0]), 32'hFF);

    // Reset in the middle of a waited write.
    xfer(1, 1'b1, 8'h14, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0, 3, "t6_pre_write");
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h18; pwdata[1] = 32'h0BAD_F00D; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    idle(2);
    rst_n = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    #2;
    check("t6 pready_in_reset", 32'(pready[1]), 32'd0);
    check("t6 err_count0_in_reset", 32'(err_count[0]), 32'd0);
    check("t6 err_count1_in_reset", 32'(err_count[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    xfer(1, 1'b0, 8'h18, 32'd0, 4'h0, 1'b0, 32'hA5A5_5A5A, 3, "t6_lost_write");
    xfer(1, 1'b0, 8'h14, 32'd0, 4'h0, 1'b0, 32'hA5A5_5A5A, 3, "t6_reg5_reset");
    xfer(1, 1'b1, 8'h18, 32'hCAFE_F00D, 4'hF, 1'b0, 32'd0, 3, "t6_b2b_write");
    xfer(1, 1'b0, 8'h18, 32'd0, 4'h0, 1'b0, 32'hCAFE_F00D, 3, "t6_b2b_read");
    xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 1'b0, 32'd0, 0, "t6_dut0_reset");
    idle(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
